// File: rtl/vga_timing_gen.sv
// Pixel-rate raster timing for the VGA DAC and frame-buffer readout.
// Counters scan (h, v); outputs are a registered decode of the pre-increment position.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active_pixels,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] r_d;
  logic [DW-1:0] w_d_next;
  logic          w_pix_en;
  logic          w_h_last;
  logic          w_v_last;
  logic [9:0]    r_h;
  logic [9:0]    r_v;

  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_act;
  logic          r_hs;
  logic          r_vs;
  logic          r_vga_clk;
  logic          r_tick;

  always_comb begin
    w_pix_en = (r_d == D_MAX);
    w_d_next = w_pix_en ? '0 : r_d + DW'(1);
    w_h_last = (r_h == H_MAX);
    w_v_last = (r_v == V_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d       <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_act     <= 1'b0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_vga_clk <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_d       <= w_d_next;
      // Low for the first half of each pixel, so the DAC samples mid-pixel
      r_vga_clk <= (w_d_next >= D_HALF);
      r_tick    <= 1'b0;
      if (w_pix_en) begin
        r_h <= w_h_last ? '0 : r_h + 10'd1;
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : r_v + 10'd1;
        end
        r_x    <= r_h;
        r_y    <= r_v;
        r_act  <= (r_h < H_ACT) && (r_v < V_ACT);
        r_hs   <= !((r_h >= HS_BEG) && (r_h < HS_END));
        r_vs   <= !((r_v >= VS_BEG) && (r_v < VS_END));
        r_tick <= (r_h == '0) && (r_v == V_ACT);
      end
    end
  end

  assign x             = r_x;
  assign y             = r_y;
  assign active_pixels = r_act;
  assign VGA_HS        = r_hs;
  assign VGA_VS        = r_vs;
  assign VGA_BLANK_N   = r_act;
  assign VGA_SYNC_N    = 1'b0;
  assign VGA_CLK       = r_vga_clk;
  assign frame_tick    = r_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster so several frames fit in a short run.
// A closed-form per-edge model feeds a scoreboard; monitors measure sync/tick timing.
module tb_vga_timing_gen;

  localparam int CD    = 2;
  localparam int HA    = 16;
  localparam int HF    = 4;
  localparam int HSW   = 6;
  localparam int HB    = 6;
  localparam int VA    = 12;
  localparam int VF    = 2;
  localparam int VSW   = 2;
  localparam int VB    = 3;
  localparam int HT    = HA + HF + HSW + HB;
  localparam int VT    = VA + VF + VSW + VB;
  localparam int LINE  = HT * CD;
  localparam int FRAME = HT * VT * CD;

  localparam logic [26:0] RST_W = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x;
  logic [9:0] y;
  logic       act;
  logic       hs;
  logic       vs;
  logic       bn;
  logic       sn;
  logic       vck;
  logic       tick;

  vga_timing_gen #(
    .CLK_DIV (CD),
    .H_ACTIVE(HA),
    .H_FP    (HF),
    .H_SYNC  (HSW),
    .H_BP    (HB),
    .V_ACTIVE(VA),
    .V_FP    (VF),
    .V_SYNC  (VSW),
    .V_BP    (VB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .x            (x),
    .y            (y),
    .active_pixels(act),
    .VGA_HS       (hs),
    .VGA_VS       (vs),
    .VGA_BLANK_N  (bn),
    .VGA_SYNC_N   (sn),
    .VGA_CLK      (vck),
    .frame_tick   (tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs after the n-th edge since reset release (edge 0 first)
  function automatic logic [26:0] expect_at(input int n);
    int q, h, v, m;
    logic a, hsb, vsb, ck, tk;
    ck = ((n + 1) % CD) >= (CD / 2);
    if (n < CD - 1) begin
      return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ck, 1'b0};
    end
    m   = n - (CD - 1);
    q   = m / CD;
    h   = q % HT;
    v   = (q / HT) % VT;
    a   = (h < HA) && (v < VA);
    hsb = !((h >= HA + HF) && (h < HA + HF + HSW));
    vsb = !((v >= VA + VF) && (v < VA + VF + VSW));
    tk  = ((m % CD) == 0) && (h == 0) && (v == VA);
    return {10'(h), 10'(v), a, hsb, vsb, a, 1'b0, ck, tk};
  endfunction

  logic [26:0] sbq[$];
  int          n_edge = 0;

  always @(posedge clk) begin
    if (rst) begin
      sbq.push_back(RST_W);
      n_edge <= 0;
    end else begin
      sbq.push_back(expect_at(n_edge));
      n_edge <= n_edge + 1;
    end
  end

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      chk("cycle", {x, y, act, hs, vs, bn, sn, vck, tick}, sbq.pop_front());
    end
  end

  logic       mon_en = 1'b0;
  logic       p_hs = 1'b1;
  logic       p_vs = 1'b1;
  logic       p_act = 1'b0;
  logic       p_vck = 1'b0;
  logic [9:0] p_x = '0;
  bit         have_hs, have_vs, have_line, have_tick;
  int         hs_cnt, vs_cnt, line_cnt, tick_cnt, act_cnt;
  int         dac_prev = -1;

  always @(negedge clk) begin
    if (!mon_en) begin
      have_hs   <= 1'b0;
      have_vs   <= 1'b0;
      have_line <= 1'b0;
      have_tick <= 1'b0;
      dac_prev  <= -1;
    end else begin
      if (!hs) hs_cnt <= hs_cnt + 1;
      if (p_hs && !hs) begin
        chk("hs_fall_x", x, HA + HF);
        hs_cnt  <= 1;
        have_hs <= 1'b1;
      end
      if (!p_hs && hs && have_hs) begin
        chk("hs_rise_x", x, HA + HF + HSW);
        chk("hs_low_clks", hs_cnt, HSW * CD);
      end

      if (!vs) vs_cnt <= vs_cnt + 1;
      if (p_vs && !vs) begin
        chk("vs_fall_y", y, VA + VF);
        vs_cnt  <= 1;
        have_vs <= 1'b1;
      end
      if (!p_vs && vs && have_vs) begin
        chk("vs_rise_y", y, VA + VF + VSW);
        chk("vs_low_clks", vs_cnt, VSW * LINE);
      end

      line_cnt <= line_cnt + 1;
      if (x == 0 && p_x != 0) begin
        if (have_line) chk("line_clks", line_cnt, LINE);
        line_cnt  <= 1;
        have_line <= 1'b1;
        if (y == 0) begin
          chk("wrap_act", act, 1);
          chk("wrap_vs", vs, 1);
        end
      end

      if (p_act && !act) chk("act_fall_x", x, HA);

      tick_cnt <= tick_cnt + 1;
      act_cnt  <= act_cnt + int'(act);
      if (tick) begin
        chk("tick_x", x, 0);
        chk("tick_y", y, VA);
        if (have_tick) begin
          chk("tick_period", tick_cnt, FRAME);
          chk("act_per_frame", act_cnt, HA * VA * CD);
        end
        tick_cnt  <= 1;
        act_cnt   <= int'(act);
        have_tick <= 1'b1;
      end

      if (vck && !p_vck) begin
        if (dac_prev >= 0) chk("dac_x", x, (dac_prev + 1) % HT);
        dac_prev <= int'(x);
      end
    end
    p_hs  <= hs;
    p_vs  <= vs;
    p_act <= act;
    p_vck <= vck;
    p_x   <= x;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_act"}, act, 0);
    chk({tag, "_blank"}, bn, 0);
    chk({tag, "_hs"}, hs, 1);
    chk({tag, "_vs"}, vs, 1);
    chk({tag, "_tick"}, tick, 0);
  endtask

  initial begin
    int k;
    rst    = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    chk("rst_vck", vck, 0);
    rst = 1'b0;

    @(posedge clk);
    #1;
    chk_reset("rel0");
    @(posedge clk);
    #1;
    chk("first_x", x, 0);
    chk("first_y", y, 0);
    chk("first_act", act, 1);
    mon_en = 1'b1;

    repeat (2 * FRAME + 3 * LINE) @(posedge clk);
    #1;

    k = 0;
    while (!(x == 10 && y == 5) && k < FRAME) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("mid_found", 32'(k < FRAME), 1);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("mid");
    chk("mid_vck", vck, 0);
    rst = 1'b0;

    k = 0;
    while (!act && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("restart_edge_idx", 32'(k - 1), CD - 1);
    chk("restart_x", x, 0);
    chk("restart_y", y, 0);
    mon_en = 1'b1;

    repeat (FRAME + 2 * LINE) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the 640x480@60 Hz display path. It divides the system clock down to a pixel rate and scans horizontal and vertical counters. It drives the pixel coordinates and the active-region flag into vga_driver_memory, and drives the sync, blank and pixel-clock pins of the VGA DAC. It also emits a once-per-frame pulse that game logic uses to update player, lava and state during vertical blanking.

## Interface
Parameters:
- CLK_DIV, 2: system clocks per pixel. Legal values are even numbers ≥2.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk, in, 1: system clock (50 MHz nominal).
- rst, in, 1: synchronous, active-high reset.
- x, out, 10: horizontal position of the current pixel.
- y, out, 10: vertical position of the current pixel.
- active_pixels, out, 1: high while the current pixel is visible.
- VGA_HS, out, 1: horizontal sync, active low.
- VGA_VS, out, 1: vertical sync, active low.
- VGA_BLANK_N, out, 1: equals active_pixels.
- VGA_SYNC_N, out, 1: constant 0.
- VGA_CLK, out, 1: pixel clock to the DAC.
- frame_tick, out, 1: one-clk pulse at the start of vertical blank.

## Operation
- Divider register d counts 0..CLK_DIV-1 and wraps. pix_en = (d == CLK_DIV-1).
- Horizontal counter h runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. h advances only on pix_en and wraps to 0.
- Vertical counter v runs 0..V_TOTAL-1, where V_TOTAL = 525. v advances on pix_en when h == H_TOTAL-1, and wraps to 0 after V_TOTAL-1.
- On every pix_en edge, the output registers load a decode of the pre-increment (h, v):
  - x = h, y = v.
  - active_pixels = (h < H_ACTIVE) && (v < V_ACTIVE).
  - VGA_HS = 0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - VGA_VS = 0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Outputs hold for CLK_DIV clks between pix_en edges.
- frame_tick is a register set on the pix_en edge that loads (h=0, v=V_ACTIVE), and cleared on the following clk edge. It is therefore exactly 1 clk wide, once per frame.
- VGA_CLK is a register loaded each clk with (d_next ≥ CLK_DIV/2). It is low for the first half of each pixel period and high for the second half, so the DAC samples mid-pixel.
- All counters are unsigned with no saturation. 10-bit widths suffice for both totals; values never exceed H_TOTAL-1 or V_TOTAL-1.

## Timing
- Reset values, all applied on the first rising clk edge with rst=1:
  - d=0, h=0, v=0.
  - x=0, y=0, active_pixels=0, VGA_BLANK_N=0.
  - VGA_HS=1, VGA_VS=1.
  - VGA_CLK=0, frame_tick=0.
- Reset mid-frame: the same values are reached on the next edge, regardless of state. No partial line or frame completes.
- Latency: with rst released before edge 0, the first pix_en edge is edge CLK_DIV-1. After that edge the outputs show pixel (0,0) with active_pixels=1.
- Outputs are registered and change only on pix_en edges. vga_driver_memory's combinational color is valid for the whole pixel period.
- Periods at CLK_DIV=2:
  - Line: 1600 clks.
  - Frame: 840000 clks.
  - frame_tick spacing: exactly 840000 clks.
  - HS low: 192 clks per line.
  - VS low: 3200 clks per frame.
- Wrap at (799, 524): the next loaded pixel is (0,0).
- On that same edge, active_pixels rises and VGA_VS is 1.

## Test plan
- Reset: hold rst for 3 clks. Required: x=0, y=0, active_pixels=0, VGA_HS=VGA_VS=1, VGA_CLK=0, frame_tick=0. One clk after release, outputs are still at reset values. After edge 1, x=0, y=0, active_pixels=1.
- Line timing: run 2 lines.
  - VGA_HS falls when x=656 and rises when x=752.
  - Low width is 192 clks; line period is 1600 clks.
  - active_pixels falls at x=640.
- Frame timing: run 2 frames.
  - VGA_VS is low exactly for y=490..491, i.e. 3200 clks.
  - frame_tick pulses 1 clk wide, coincident with the load of (0,480), and repeats every 840000 clks.
- Active count: count clks with active_pixels=1 over one frame. Required: 614400 (640·480·2).
- VGA_CLK phase: the DAC model samples x on VGA_CLK rising edges. Required: it sees 0,1,2,…,799 with no repeats or skips.
- Mid-frame reset: assert rst for 1 clk at (x=300, y=200). Next edge shows all reset values. Scan restarts, and pixel (0,0) appears CLK_DIV-1 edges after release.
